// File: rtl/add_subtract.sv
// add_subtract: registered add/subtract slice for the execute stage.
// One-cycle latency; result and carry/zero/negative/overflow flags are
// registered together and held unchanged on undefined opcodes. The
// registered carry doubles as the carry/borrow input for ADDC/SUBB chains.
module add_subtract #(
    parameter int WIDTH = 4,
    parameter int OPW   = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(3);
    localparam logic [OPW-1:0] OP_ADDC = OPW'(4);
    localparam logic [OPW-1:0] OP_SUBB = OPW'(5);
    localparam int MSB = WIDTH - 1;

    // Signed overflow of an addition: like-signed operands, result sign differs.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    // Signed overflow of a subtraction: unlike-signed operands, result sign differs from a.
    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    logic [WIDTH:0]   ext_a;
    logic [WIDTH:0]   ext_b;
    logic [WIDTH:0]   cin_ext;
    logic [WIDTH:0]   res_full;
    logic [WIDTH-1:0] res;
    logic             is_sub;
    logic             load;
    logic             nxt_carry;
    logic             nxt_ovf;

    // Next-state datapath: WIDTH+1-bit sum/difference; the top bit is carry or borrow.
    always_comb begin
        ext_a    = {1'b0, a};
        ext_b    = {1'b0, b};
        cin_ext  = {{WIDTH{1'b0}}, carry};
        res_full = '0;
        is_sub   = 1'b0;
        load     = 1'b0;
        case (op)
            OP_ADD: begin
                load     = 1'b1;
                res_full = ext_a + ext_b;
            end
            OP_SUB: begin
                load     = 1'b1;
                is_sub   = 1'b1;
                res_full = ext_a - ext_b;
            end
            OP_ADDC: begin
                load     = 1'b1;
                res_full = ext_a + ext_b + cin_ext;
            end
            OP_SUBB: begin
                load     = 1'b1;
                is_sub   = 1'b1;
                // Borrow out of the full-precision a - (b + cin) lands in the top bit.
                res_full = ext_a - ext_b - cin_ext;
            end
            default: begin
                load = 1'b0;
            end
        endcase
        res       = res_full[WIDTH-1:0];
        nxt_carry = res_full[WIDTH];
        nxt_ovf   = is_sub ? sub_ovf(a[MSB], b[MSB], res[MSB])
                           : add_ovf(a[MSB], b[MSB], res[MSB]);
    end

    // Output register: all five fields load together on defined opcodes only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out      <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else if (load) begin
            out      <= res;
            carry    <= nxt_carry;
            zero     <= (res == '0);
            negative <= res[MSB];
            overflow <= nxt_ovf;
        end
    end

endmodule

// File: tb/tb_add_subtract.sv
// Scoreboard bench for add_subtract: the driver pushes hand-computed
// expectations as it issues each vector; a monitor pops one per clock
// edge and compares {out, carry, zero, negative, overflow}.
`timescale 1ns/1ps
module tb_add_subtract;

    localparam int WIDTH = 4;
    localparam int OPW   = 4;

    localparam logic [3:0] ADD  = 4'b0010;
    localparam logic [3:0] SUB  = 4'b0011;
    localparam logic [3:0] ADDC = 4'b0100;
    localparam logic [3:0] SUBB = 4'b0101;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [OPW-1:0]   op = ADD;
    logic [WIDTH-1:0] a = 4'b1111;
    logic [WIDTH-1:0] b = 4'b1111;
    logic [WIDTH-1:0] out;
    logic             carry, zero, negative, overflow;

    typedef struct {
        string      name;
        logic [7:0] value;   // {out, carry, zero, negative, overflow}
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;

    add_subtract #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .op       (op),
        .a        (a),
        .b        (b),
        .out      (out),
        .carry    (carry),
        .zero     (zero),
        .negative (negative),
        .overflow (overflow)
    );

    always #10 clock = ~clock;

    function automatic logic [7:0] packv(input logic [3:0] o, input logic c, input logic z,
                                         input logic n, input logic v);
        return {o, c, z, n, v};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got out=%b c=%b z=%b n=%b v=%b, expected out=%b c=%b z=%b n=%b v=%b",
                      name, got[7:4], got[3], got[2], got[1], got[0],
                      want[7:4], want[3], want[2], want[1], want[0]);
    endtask

    // Drive one vector on the falling edge and record what the next rising edge must produce.
    task automatic apply(input string name, input logic [3:0] o, input logic [3:0] ia,
                         input logic [3:0] ib, input logic [7:0] want);
        exp_t e;
        @(negedge clock);
        op = o;
        a  = ia;
        b  = ib;
        e.name  = name;
        e.value = want;
        exp_q.push_back(e);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clock);
            #3;
            n++;
        end
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    endtask

    // Monitor: one registered result per rising edge while expectations are pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(e.name, {out, carry, zero, negative, overflow}, e.value);
            end
        end
    end

    initial begin
        // Reset held with a live ADD on the inputs: outputs stay cleared.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_hold", {out, carry, zero, negative, overflow}, 8'h00);

        reset_n = 1'b1;
        begin
            exp_t e;
            e.name  = "post_reset_add";
            e.value = packv(4'b1110, 1, 0, 1, 0);
            exp_q.push_back(e);
        end

        apply("add_8_1", ADD, 4'b1000, 4'b0001, packv(4'b1001, 0, 0, 1, 0));
        apply("add_9_3", ADD, 4'b1001, 4'b0011, packv(4'b1100, 0, 0, 1, 0));
        apply("add_f_3", ADD, 4'b1111, 4'b0011, packv(4'b0010, 1, 0, 0, 0));
        apply("add_f_7", ADD, 4'b1111, 4'b0111, packv(4'b0110, 1, 0, 0, 0));
        apply("add_9_7", ADD, 4'b1001, 4'b0111, packv(4'b0000, 1, 1, 0, 0));

        apply("sub_3_5", SUB, 4'b0011, 4'b0101, packv(4'b1110, 1, 0, 1, 0));
        apply("sub_7_8", SUB, 4'b0111, 4'b1000, packv(4'b1111, 1, 0, 1, 1));
        apply("sub_5_5", SUB, 4'b0101, 4'b0101, packv(4'b0000, 0, 1, 0, 0));
        apply("sub_0_1", SUB, 4'b0000, 4'b0001, packv(4'b1111, 1, 0, 1, 0));
        apply("sub_8_1", SUB, 4'b1000, 4'b0001, packv(4'b0111, 0, 0, 0, 1));

        apply("chain_add", ADD,  4'b1111, 4'b0001, packv(4'b0000, 1, 1, 0, 0));
        apply("chain_addc", ADDC, 4'b0000, 4'b0000, packv(4'b0001, 0, 0, 0, 0));
        apply("chain_sub", SUB,  4'b0000, 4'b0001, packv(4'b1111, 1, 0, 1, 0));
        apply("chain_subb", SUBB, 4'b0001, 4'b0000, packv(4'b0000, 0, 1, 0, 0));
        apply("addc_no_cin", ADDC, 4'b0110, 4'b0001, packv(4'b0111, 0, 0, 0, 0));
        apply("carry_set", ADD,  4'b1111, 4'b0001, packv(4'b0000, 1, 1, 0, 0));
        apply("addc_cin_wrap", ADDC, 4'b0111, 4'b1000, packv(4'b0000, 1, 1, 0, 0));
        apply("subb_cin", SUBB, 4'b0101, 4'b0010, packv(4'b0010, 0, 0, 0, 0));

        apply("nop_base", ADD, 4'b1001, 4'b0011, packv(4'b1100, 0, 0, 1, 0));
        apply("nop_0000", 4'b0000, 4'b0101, 4'b0110, packv(4'b1100, 0, 0, 1, 0));
        apply("nop_1111", 4'b1111, 4'b1010, 4'b0011, packv(4'b1100, 0, 0, 1, 0));

        apply("pre_reset", ADD, 4'b1111, 4'b0010, packv(4'b0001, 1, 0, 0, 0));
        wait_empty();

        // Asynchronous reset pulse between edges clears outputs without a clock.
        #1 reset_n = 1'b0;
        #1 check("async_reset", {out, carry, zero, negative, overflow}, 8'h00);
        #1 reset_n = 1'b1;

        apply("addc_after_reset", ADDC, 4'b0010, 4'b0011, packv(4'b0101, 0, 0, 0, 0));
        wait_empty();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Watchdog: the run must end on its own.
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/add_subtract.md
Name: add_subtract

Overview:
- Registered 4-bit (parameterisable) add/subtract datapath slice, driven by a 4-bit opcode.
- Produces a result plus carry/zero/negative/overflow flags one clock after the operands are presented.
- Stored carry supports multi-word add/subtract chains.
- Sits in the CPU execute stage; the register file or control unit drives the opcode and operands.

Parameters:
- WIDTH, 4, operand/result width in bits (legal range 2..32).
- OPW, 4, opcode width in bits (fixed at 4 for the current ISA).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- op  input  OPW  operation select, sampled every rising edge.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out  output  WIDTH  registered result.
- carry  output  1  registered carry/borrow flag; also the stored carry used by ADDC/SUBB.
- zero  output  1  registered: 1 when out == 0.
- negative  output  1  registered: copy of out[WIDTH-1].
- overflow  output  1  registered signed (two's-complement) overflow.

Behaviour:
- Reset: reset_n low asynchronously clears out, carry, zero, negative and overflow to 0. All hold 0 while reset_n is low. Normal operation starts on the first rising edge after deassertion.
- Latency: 1 cycle. On rising edge k, op/a/b are sampled; out and flags show the result after edge k. New operands are accepted every cycle; there is no handshake.
- Opcodes (op value, operation, then carry and overflow rules):
  - 4'b0010 ADD: out = a + b. carry = bit WIDTH of the (WIDTH+1)-bit sum. overflow = (a[MSB]==b[MSB]) && (out[MSB]!=a[MSB]).
  - 4'b0011 SUB: out = a - b (mod 2^WIDTH). carry = borrow, 1 when a < b unsigned. overflow = (a[MSB]!=b[MSB]) && (out[MSB]!=a[MSB]).
  - 4'b0100 ADDC: out = a + b + carry (current registered carry). Flags as ADD, carry-in included.
  - 4'b0101 SUBB: out = a - b - carry. carry = 1 when a < b + carry_in (unsigned, full precision). Overflow as SUB on the full result.
  - All other codes: hold out and all four flags unchanged (NOP).
- Flag rules:
  - zero and negative always derive from the new out value.
  - All five registers update together, only on the four defined opcodes.
- Width: internal sum/difference computed at WIDTH+1 bits. Result wraps modulo 2^WIDTH.
- Boundaries:
  - All-ones + 1 wraps to 0 with carry=1, zero=1.
  - 0 - 1 gives all-ones with carry=1, negative=1.
  - Signed most-negative minus 1 sets overflow.
- Reset mid-operation: asserting reset_n discards the in-flight sample. Outputs clear immediately, without waiting for a clock edge.
- Operand or opcode changes between edges have no effect until the next rising edge.
- Inputs are purely combinational into the next-state logic; there are no internal pipeline stages beyond the output register.

Test Plan:
- Reset: hold reset_n=0 with op=0010, a=1111, b=1111 and toggle clock -> out=0000, all flags 0. Deassert; next edge -> out=1110, carry=1, negative=1, overflow=0.
- ADD sequence, op=0010, one result per edge:
  - 1000+0001 -> out=1001, carry=0, overflow=0.
  - 1001+0011 -> 1100.
  - 1111+0011 -> 0010, carry=1.
  - 1111+0111 -> 0110, carry=1.
  - 1001+0111 -> 0000, carry=1, zero=1.
- SUB, op=0011:
  - 0011-0101 -> 1110, carry=1, negative=1, overflow=0.
  - 0111-1000 -> 1111, overflow=1.
  - 0101-0101 -> 0000, zero=1, carry=0.
- Multi-word chain:
  - ADD 1111+0001 -> 0000, carry=1; then ADDC 0000+0000 -> 0001, carry=0.
  - SUB 0000-0001 -> 1111, carry=1; then SUBB 0001-0000 -> 0000, zero=1, carry=0.
- NOP hold: after ADD giving 1100, apply op=0000 then op=1111 with changing a/b -> out stays 1100, flags unchanged for both cycles.
- Async reset mid-stream: pulse reset_n low between clock edges after a nonzero result -> outputs 0 immediately. The next defined op computes normally, with ADDC seeing carry-in 0.
